// File: rtl/adder_vector_engine.sv
// -----------------------------------------------------------------------------
// adder_vector_engine
//
// Stimulus/response engine wrapped around a combinational adder. It drives
// registered operands (a, b, cin), and one cycle later checks the adder's
// {cout, sum} against an internally computed a+b+cin. It counts compares and
// mismatches and remembers the operands of the first mismatch.
//
// Each run first issues four directed corner vectors. It then issues
// NUM_RANDOM pseudo-random vectors taken from two xorshift64 generators,
// spends one drain cycle on the last compare, and settles in DONE.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous reset, active low
//   start        in   1      one-cycle pulse; accepted only in IDLE or DONE
//   a, b         out  WIDTH  registered adder operands
//   cin          out  1      registered adder carry-in
//   sum          in   WIDTH  adder sum (combinational from a/b/cin)
//   cout         in   1      adder carry-out
//   busy         out  1      high from start-accept through the last compare
//   done         out  1      high while in DONE
//   pass         out  1      with done: no mismatches were seen
//   vec_count    out  CNT_W  compares made this run (saturating)
//   err_count    out  CNT_W  mismatches this run (saturating)
//   first_err_a  out  WIDTH  a of the first mismatching vector, else 0
//   first_err_b  out  WIDTH  b of the first mismatching vector, else 0
// -----------------------------------------------------------------------------
module adder_vector_engine #(
  parameter int          WIDTH      = 32,
  parameter int          NUM_RANDOM = 1024,
  parameter int          CNT_W      = 16,
  parameter logic [63:0] SEED_A     = 64'h0123456789ABCDEF,
  parameter logic [63:0] SEED_B     = 64'hFEDCBA9876543210
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  // An all-zero xorshift state never leaves zero, so a zero seed is replaced.
  localparam logic [63:0] SEED_A_EFF = (SEED_A == 64'd0) ? 64'd1 : SEED_A;
  localparam logic [63:0] SEED_B_EFF = (SEED_B == 64'd0) ? 64'd1 : SEED_B;

  // Random-phase counter holds 0 .. NUM_RANDOM-1.
  localparam int            RC_W      = (NUM_RANDOM > 1) ? $clog2(NUM_RANDOM) : 1;
  localparam logic [RC_W-1:0] LAST_RAND = RC_W'(NUM_RANDOM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORNER,
    S_RANDOM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [1:0]       corner_idx;
  logic [RC_W-1:0]  rand_cnt;
  logic [63:0]      sa, sb;
  logic [63:0]      next_sa, next_sb;
  logic [WIDTH:0]   golden;      // {g_cout, g_sum} of the vector now on a/b/cin
  logic             cmp_valid;   // a/b/cin hold a vector still awaiting its compare

  logic             start_ok;
  logic             issue;
  logic [WIDTH-1:0] issue_a, issue_b;
  logic             issue_cin;
  logic [WIDTH:0]   issue_sum;
  logic             mismatch;

  // xorshift64 step: x ^= x<<13; x ^= x>>7; x ^= x<<17.
  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  assign next_sa  = xorshift64(sa);
  assign next_sb  = xorshift64(sb);
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign mismatch = ({cout, sum} != golden);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments. Every register then
      // samples values from before the edge, whatever the process order.
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, status outputs, and selection of the vector to issue
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case. Any path that leaves
    // a signal unassigned would otherwise infer a latch.
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    issue      = 1'b0;
    issue_a    = '0;
    issue_b    = '0;
    issue_cin  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) next_state = S_CORNER;
      end

      S_CORNER: begin
        busy  = 1'b1;
        issue = 1'b1;
        unique case (corner_idx)
          2'd0: begin issue_a = '0; issue_b = '0;           issue_cin = 1'b0; end
          2'd1: begin issue_a = '1; issue_b = WIDTH'(1);    issue_cin = 1'b0; end
          2'd2: begin issue_a = '1; issue_b = '1;           issue_cin = 1'b1; end
          2'd3: begin issue_a = '1; issue_b = '0;           issue_cin = 1'b1; end
          default: ;
        endcase
        if (corner_idx == 2'd3) next_state = S_RANDOM;
      end

      S_RANDOM: begin
        busy      = 1'b1;
        issue     = 1'b1;
        issue_a   = next_sa[WIDTH-1:0];
        issue_b   = next_sb[WIDTH-1:0];
        issue_cin = next_sa[63];
        if (rand_cnt == LAST_RAND) next_state = S_DRAIN;
      end

      S_DRAIN: begin
        busy       = 1'b1;
        next_state = S_DONE;
      end

      S_DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) next_state = S_CORNER;
      end

      default: next_state = S_IDLE;
    endcase
  end

  // The golden value is computed one bit wider so it keeps the carry-out.
  assign issue_sum = {1'b0, issue_a} + {1'b0, issue_b} + {{WIDTH{1'b0}}, issue_cin};

  // ---------------------------------------------------------------------------
  // Datapath: issue, golden capture, compare and counting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a           <= '0;
      b           <= '0;
      cin         <= 1'b0;
      golden      <= '0;
      cmp_valid   <= 1'b0;
      corner_idx  <= '0;
      rand_cnt    <= '0;
      sa          <= SEED_A_EFF;
      sb          <= SEED_B_EFF;
      vec_count   <= '0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else if (start_ok) begin
      // A new run clears its results and replays the same random sequence.
      // a/b/cin keep the previous vector until the first corner vector issues.
      cmp_valid   <= 1'b0;
      corner_idx  <= '0;
      rand_cnt    <= '0;
      sa          <= SEED_A_EFF;
      sb          <= SEED_B_EFF;
      vec_count   <= '0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else begin
      // Compare the vector issued on the previous edge. a/b still hold that
      // vector here, because this edge's issue lands only after the edge.
      if (cmp_valid) begin
        if (vec_count != '1) vec_count <= vec_count + CNT_W'(1);
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (err_count == '0) begin
            first_err_a <= a;
            first_err_b <= b;
          end
        end
      end

      cmp_valid <= issue;
      if (issue) begin
        a      <= issue_a;
        b      <= issue_b;
        cin    <= issue_cin;
        golden <= issue_sum;
      end

      if (state == S_CORNER) corner_idx <= corner_idx + 2'd1;

      if (state == S_RANDOM) begin
        sa       <= next_sa;
        sb       <= next_sb;
        rand_cnt <= rand_cnt + RC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_vector_engine.sv
// -----------------------------------------------------------------------------
// tb_adder_vector_engine
//
// Bench for adder_vector_engine. The main instance (WIDTH=32, NUM_RANDOM=16)
// drives a behavioural adder that can flip sum[0] on the V1 corner vector or
// hold cout at 0. A second instance (WIDTH=8, NUM_RANDOM=8, CNT_W=2) drives an
// adder that is always off by one, so its counters saturate.
//
// At each start, the bench pushes the expected vector sequence onto a queue.
// The sequence comes from the corner table and a local xorshift model. Each
// vector is popped and compared when the DUT issues it.
// -----------------------------------------------------------------------------
module tb_adder_vector_engine;

  localparam int W  = 32;
  localparam int NR = 16;
  localparam int NV = 4 + NR;

  localparam logic [63:0] SEED_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] SEED_B = 64'hFEDCBA9876543210;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic start  = 1'b0;
  logic start2 = 1'b0;

  always #5 clk = ~clk;

  // Main DUT and its adder
  logic [W-1:0] a, b, sum, fa, fb;
  logic         cin, cout, busy, done, pass;
  logic [15:0]  vc, ec;
  int           fault_mode = 0;
  logic [W:0]   t_res;

  always_comb begin
    t_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sum   = t_res[W-1:0];
    cout  = t_res[W];
    if (fault_mode == 1 && a == '1 && b == W'(1) && !cin) sum[0] = ~t_res[0];
    if (fault_mode == 2) cout = 1'b0;
  end

  adder_vector_engine #(
    .WIDTH(W), .NUM_RANDOM(NR), .CNT_W(16), .SEED_A(SEED_A), .SEED_B(SEED_B)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vc), .err_count(ec),
    .first_err_a(fa), .first_err_b(fb)
  );

  // Saturation DUT with an always-wrong adder
  logic [7:0] a2, b2, sum2, fa2, fb2;
  logic       cin2, cout2, busy2, done2, pass2;
  logic [1:0] vc2, ec2;
  logic [8:0] t2;

  always_comb begin
    t2    = {1'b0, a2} + {1'b0, b2} + {8'd0, cin2} + 9'd1;
    sum2  = t2[7:0];
    cout2 = t2[8];
  end

  adder_vector_engine #(
    .WIDTH(8), .NUM_RANDOM(8), .CNT_W(2), .SEED_A(SEED_A), .SEED_B(SEED_B)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .a(a2), .b(b2), .cin(cin2), .sum(sum2), .cout(cout2),
    .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vc2), .err_count(ec2),
    .first_err_a(fa2), .first_err_b(fb2)
  );

  // Checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         cout_e;
    logic [W-1:0] sum_e;
  } corner_t;

  corner_t corners[4];
  vec_t    exp_q[$];

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  // Builds the expected vector sequence and predicts the error results of
  // the given fault mode.
  task automatic build(input int mode, output int e_err,
                       output logic [W-1:0] e_fa, output logic [W-1:0] e_fb);
    logic [63:0] sa, sb;
    exp_q.delete();
    sa    = SEED_A;
    sb    = SEED_B;
    e_err = 0;
    e_fa  = '0;
    e_fb  = '0;
    for (int i = 0; i < NV; i++) begin
      vec_t       v;
      logic [W:0] tr;
      logic       bad;
      if (i < 4) begin
        v.a   = corners[i].a;
        v.b   = corners[i].b;
        v.cin = corners[i].cin;
      end else begin
        sa    = xs(sa);
        sb    = xs(sb);
        v.a   = sa[W-1:0];
        v.b   = sb[W-1:0];
        v.cin = sa[63];
      end
      tr  = {1'b0, v.a} + {1'b0, v.b} + {{W{1'b0}}, v.cin};
      bad = (mode == 1 && v.a == '1 && v.b == W'(1) && !v.cin) || (mode == 2 && tr[W]);
      if (bad) begin
        if (e_err == 0) begin
          e_fa = v.a;
          e_fb = v.b;
        end
        e_err++;
      end
      exp_q.push_back(v);
    end
  endtask

  // One full run on the main DUT. mid_start injects an extra start pulse:
  // 1 while in RANDOM, 2 on the DRAIN->DONE edge. Both must be ignored.
  task automatic run(input int mode, input int mid_start, input string tag);
    int           e_err, cyc, busy_n;
    logic [W-1:0] e_fa, e_fb;
    vec_t         v, last_v;
    fault_mode = mode;
    build(mode, e_err, e_fa, e_fb);
    last_v = exp_q[NV-1];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    cyc    = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) busy_n++;
      if (cyc <= NV && exp_q.size() > 0) begin
        v = exp_q.pop_front();
        check($sformatf("%s vec%0d", tag, cyc - 1), {a, b, cin}, {v.a, v.b, v.cin});
        if (mode == 0 && cyc <= 4)
          check($sformatf("%s corner%0d sum", tag, cyc - 1), {cout, sum},
                {corners[cyc-1].cout_e, corners[cyc-1].sum_e});
      end
      if (mid_start == 1 && cyc == 10) start = 1'b1;
      if (mid_start == 1 && cyc == 11) start = 1'b0;
      if (mid_start == 2 && cyc == 20) start = 1'b1;
      if (mid_start == 2 && cyc == 21) start = 1'b0;
    end
    start = 1'b0;
    check({tag, " done reached"}, done, 1'b1);
    check({tag, " done latency"}, cyc, NV + 1);
    check({tag, " busy cycles"}, busy_n, NV + 1);
    check({tag, " vec_count"}, vc, NV);
    check({tag, " err_count"}, ec, e_err);
    check({tag, " pass"}, pass, (e_err == 0));
    check({tag, " first_err_a"}, fa, e_fa);
    check({tag, " first_err_b"}, fb, e_fb);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold done/busy"}, {done, busy}, 2'b10);
    check({tag, " hold vec_count"}, vc, NV);
    check({tag, " hold last vector"}, {a, b, cin}, {last_v.a, last_v.b, last_v.cin});
  endtask

  initial begin
    int cyc;
    corners[0] = '{32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    corners[1] = '{32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 32'h0};
    corners[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF};
    corners[3] = '{32'hFFFFFFFF, 32'h0,        1'b1, 1'b1, 32'h0};

    // Reset state
    #1;
    check("reset a/b/cin", {a, b, cin}, '0);
    check("reset status", {busy, done, pass}, 3'b000);
    check("reset counts", {vc, ec}, 32'h0);
    check("reset first_err", {fa, fb}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Clean adder, corner sequence, ignored start during RANDOM
    run(0, 1, "clean");
    // sum[0] flipped on V1 only
    run(1, 0, "v1fault");
    // cout stuck at 0, plus a start on the DRAIN->DONE edge
    run(2, 2, "cout0");

    // Reset during RANDOM, then replay
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("midrun busy before reset", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midrun reset a/b/cin", {a, b, cin}, '0);
    check("midrun reset status", {busy, done, pass}, 3'b000);
    check("midrun reset counts", {vc, ec}, 32'h0);
    check("midrun reset first_err", {fa, fb}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle after reset", {busy, done, vc}, 18'h0);
    run(0, 0, "replay");

    // Saturating counters on the narrow instance
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    cyc    = 0;
    while (!done2 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sat done latency", cyc, 13);
    check("sat done/pass", {done2, pass2}, 2'b10);
    check("sat vec_count", vc2, 2'd3);
    check("sat err_count", ec2, 2'd3);
    check("sat first_err", {fa2, fb2}, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
